// File: rtl/io_port_pkg.sv
// io_port_pkg
// Shared definitions for the io_port_ctrl memory-mapped I/O block:
//   - default register addresses for switches, status and display
//   - segment bit positions within the 7-bit {g,f,e,d,c,b,a} vector
//   - the 16-entry hex seven-segment table and its lookup function
package io_port_pkg;

  localparam logic [15:0] IO_ADDR_SW_DEF   = 16'hFFF0;
  localparam logic [15:0] IO_ADDR_STAT_DEF = 16'hFFF2;
  localparam logic [15:0] IO_ADDR_DISP_DEF = 16'hFFF4;

  // Bit index of each segment in the display vector, a is the LSB.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high segment patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Pattern for a 5-bit display word: bit 4 enables, bits 3:0 select the digit.
  function automatic logic [6:0] seg_decode(input logic [4:0] disp);
    logic [6:0] seg_s;
    if (disp[4]) begin
      seg_s = SEG_TABLE[disp[3:0]];
    end else begin
      seg_s = 7'b0000000;
    end
    return seg_s;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer
// Two-flop synchronizer followed by a debouncer for one asynchronous switch.
// Configuration macro: IO_DEBOUNCE_EN
//   defined   - a new synchronized value must persist DEBOUNCE_CYCLES edges
//               before it is accepted as the stable value.
//   undefined - the second synchronizer flop is the stable value itself;
//               DEBOUNCE_CYCLES has no effect.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-low reset
//   sw_raw     in   raw asynchronous switch input
//   stable     out  debounced switch value (registered)
//   chg_set    out  high in the cycle before the edge at which stable changes;
//                   the parent samples it on that edge to set its change flag
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  output logic stable,
  output logic chg_set
);

  logic s1_r;
  logic s2_r;

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronizer, persistence counter and stable value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      s1_r <= sw_raw;
      s2_r <= s1_r;
      if (s2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        stable_r <= s2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stable  = stable_r;
  assign chg_set = (s2_r != stable_r) && (cnt_r == CNT_MAX);
`else
  // Synchronizer only; the second flop is the stable value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= sw_raw;
      s2_r <= s1_r;
    end
  end

  assign stable  = s2_r;
  assign chg_set = (s1_r != s2_r);
`endif

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl
// Memory-mapped I/O peripheral on the 16-bit data bus: two debounced switches
// with read-to-clear change flags, and a display register driving a
// 7-segment output.
// Configuration macro: IO_DEBOUNCE_EN (see switch_debouncer).
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-low reset
//   dmemaddr    in   [15:0] bus address
//   dmemwdata   in   [15:0] bus write data
//   dmemwrite   in   write enable
//   dmemread    in   read enable
//   io_sw0      in   raw switch 0 (asynchronous)
//   io_sw1      in   raw switch 1 (asynchronous)
//   io_rdata    out  [15:0] read data, combinational from registered state
//   io_hit      out  address matches one of the three registers
//   io_display  out  [6:0] segments {g,f,e,d,c,b,a}, active-high, registered
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [15:0] ADDR_SW         = IO_ADDR_SW_DEF,
  parameter logic [15:0] ADDR_STAT       = IO_ADDR_STAT_DEF,
  parameter logic [15:0] ADDR_DISP       = IO_ADDR_DISP_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  input  logic        io_sw0,
  input  logic        io_sw1,
  output logic [15:0] io_rdata,
  output logic        io_hit,
  output logic [6:0]  io_display
);

  logic       sw0_stable_s;
  logic       sw1_stable_s;
  logic       sw0_chg_set_s;
  logic       sw1_chg_set_s;
  logic       chg0_r;
  logic       chg1_r;
  logic [4:0] disp_r;
  logic [6:0] display_r;
  logic       hit_sw_s;
  logic       hit_stat_s;
  logic       hit_disp_s;
  logic       stat_clr_s;
  logic       disp_wr_s;
  logic [15:0] rdata_s;

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
    .clock   (clock),
    .reset   (reset),
    .sw_raw  (io_sw0),
    .stable  (sw0_stable_s),
    .chg_set (sw0_chg_set_s)
  );

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
    .clock   (clock),
    .reset   (reset),
    .sw_raw  (io_sw1),
    .stable  (sw1_stable_s),
    .chg_set (sw1_chg_set_s)
  );

  assign hit_sw_s   = (dmemaddr == ADDR_SW);
  assign hit_stat_s = (dmemaddr == ADDR_STAT);
  assign hit_disp_s = (dmemaddr == ADDR_DISP);
  assign stat_clr_s = dmemread  && hit_stat_s;
  assign disp_wr_s  = dmemwrite && hit_disp_s;

  // Change flags: a new switch acceptance beats a status read-clear on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      chg0_r <= 1'b0;
      chg1_r <= 1'b0;
    end else begin
      if (sw0_chg_set_s) begin
        chg0_r <= 1'b1;
      end else if (stat_clr_s) begin
        chg0_r <= 1'b0;
      end else begin
        chg0_r <= chg0_r;
      end
      if (sw1_chg_set_s) begin
        chg1_r <= 1'b1;
      end else if (stat_clr_s) begin
        chg1_r <= 1'b0;
      end else begin
        chg1_r <= chg1_r;
      end
    end
  end

  // Display register; segments are decoded from the write data so the
  // output changes on the same edge as the register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      disp_r    <= 5'b00000;
      display_r <= 7'b0000000;
    end else if (disp_wr_s) begin
      disp_r    <= dmemwdata[4:0];
      display_r <= seg_decode(dmemwdata[4:0]);
    end else begin
      disp_r    <= disp_r;
      display_r <= display_r;
    end
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rdata_s = 16'h0000;
    case (1'b1)
      hit_sw_s:   rdata_s = {14'b0, sw1_stable_s, sw0_stable_s};
      hit_stat_s: rdata_s = {14'b0, chg1_r, chg0_r};
      hit_disp_s: rdata_s = {11'b0, disp_r};
      default:    rdata_s = 16'h0000;
    endcase
  end

  assign io_rdata   = rdata_s;
  assign io_hit     = hit_sw_s || hit_stat_s || hit_disp_s;
  assign io_display = display_r;

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

  localparam logic [15:0] A_SW   = 16'hFFF0;
  localparam logic [15:0] A_STAT = 16'hFFF2;
  localparam logic [15:0] A_DISP = 16'hFFF4;
`ifdef IO_DEBOUNCE_EN
  localparam int SW_LAT = 6;
`else
  localparam int SW_LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic        io_sw0;
  logic        io_sw1;
  logic [15:0] io_rdata;
  logic        io_hit;
  logic [6:0]  io_display;

  int checks = 0;
  int errors = 0;

  io_port_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .dmemaddr   (dmemaddr),
    .dmemwdata  (dmemwdata),
    .dmemwrite  (dmemwrite),
    .dmemread   (dmemread),
    .io_sw0     (io_sw0),
    .io_sw1     (io_sw1),
    .io_rdata   (io_rdata),
    .io_hit     (io_hit),
    .io_display (io_display)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    dmemaddr = addr;
    #1;
    check(tag, io_rdata, exp);
  endtask

  initial begin
    reset = 1'b0; dmemaddr = 16'h0000; dmemwdata = 16'h0000;
    dmemwrite = 1'b0; dmemread = 1'b0; io_sw0 = 1'b1; io_sw1 = 1'b0;
    tick(2);
    check("rst_display", {9'b0, io_display}, 16'h0000);
    check("rst_nohit", {15'b0, io_hit}, 16'h0000);
    check("rst_rdata_unmapped", io_rdata, 16'h0000);
    rd("rst_sw", A_SW, 16'h0000);
    check("rst_hit_sw", {15'b0, io_hit}, 16'h0001);
    // reset with write pending: reset wins
    dmemaddr = A_DISP; dmemwdata = 16'h0015; dmemwrite = 1'b1;
    tick(1);
    dmemwrite = 1'b0;
    check("rst_over_write", {9'b0, io_display}, 16'h0000);

    // release; sw0=1 must appear after SW_LAT edges
    reset = 1'b1;
    tick(SW_LAT - 1);
    rd("sw0_before_lat", A_SW, 16'h0000);
    tick(1);
    rd("sw0_at_lat", A_SW, 16'h0001);
    rd("stat_sw0", A_STAT, 16'h0001);

    // read-to-clear
    dmemread = 1'b1;
    rd("stat_read1", A_STAT, 16'h0001);
    tick(1);
    rd("stat_read2", A_STAT, 16'h0000);
    dmemread = 1'b0;

    // set and clear on the same edge: set wins
    io_sw0 = 1'b0;
    tick(SW_LAT - 1);
    rd("sw0_fall_pending", A_SW, 16'h0001);
    dmemread = 1'b1;
    rd("stat_before_same_edge", A_STAT, 16'h0000);
    tick(1);
    dmemread = 1'b0;
    rd("stat_set_wins", A_STAT, 16'h0001);
    rd("sw0_fell", A_SW, 16'h0000);
    dmemread = 1'b1; dmemaddr = A_STAT;
    tick(1);
    dmemread = 1'b0;
    rd("stat_cleared", A_STAT, 16'h0000);

    // display writes
    dmemaddr = A_DISP; dmemwdata = 16'h0015; dmemwrite = 1'b1;
    tick(1);
    dmemwrite = 1'b0;
    check("disp_5", {9'b0, io_display}, 16'h006D);
    rd("disp_rb_15", A_DISP, 16'h0015);
    dmemwdata = 16'h0005; dmemwrite = 1'b1;
    tick(1);
    dmemwrite = 1'b0;
    check("disp_off", {9'b0, io_display}, 16'h0000);
    rd("disp_rb_05", A_DISP, 16'h0005);
    dmemwdata = 16'h001A; dmemwrite = 1'b1;
    tick(1);
    dmemwrite = 1'b0;
    check("disp_A", {9'b0, io_display}, 16'h0077);
    // simultaneous read/write: read sees old value, write lands
    dmemwdata = 16'h0010; dmemwrite = 1'b1; dmemread = 1'b1;
    rd("rw_old_value", A_DISP, 16'h001A);
    tick(1);
    dmemwrite = 1'b0; dmemread = 1'b0;
    check("disp_0", {9'b0, io_display}, 16'h003F);
    rd("disp_rb_10", A_DISP, 16'h0010);

    // unmapped write is ignored
    dmemaddr = 16'hFFF6; dmemwdata = 16'h001F; dmemwrite = 1'b1;
    #1;
    check("unmapped_hit", {15'b0, io_hit}, 16'h0000);
    check("unmapped_rdata", io_rdata, 16'h0000);
    tick(1);
    dmemwrite = 1'b0;
    check("unmapped_disp", {9'b0, io_display}, 16'h003F);
    rd("unmapped_disp_rb", A_DISP, 16'h0010);

`ifdef IO_DEBOUNCE_EN
    // 3-cycle glitch on sw1 is rejected
    io_sw1 = 1'b1;
    tick(3);
    io_sw1 = 1'b0;
    tick(10);
    rd("glitch_sw", A_SW, 16'h0000);
    rd("glitch_stat", A_STAT, 16'h0000);
    // held input accepted after exactly 6 edges
    io_sw1 = 1'b1;
    tick(5);
    rd("hold_sw_5", A_SW, 16'h0000);
    tick(1);
    rd("hold_sw_6", A_SW, 16'h0002);
    rd("hold_stat", A_STAT, 16'h0002);
    tick(4);
    // reset mid-debounce discards the count
    io_sw1 = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    io_sw1 = 1'b1;
    tick(5);
    rd("post_reset_sw_5", A_SW, 16'h0000);
    tick(1);
    rd("post_reset_sw_6", A_SW, 16'h0002);
`else
    // 1-cycle glitch on sw0 passes straight through with 2-edge latency
    io_sw0 = 1'b1;
    tick(1);
    io_sw0 = 1'b0;
    rd("glitch_sw_1", A_SW, 16'h0000);
    tick(1);
    rd("glitch_sw_2", A_SW, 16'h0001);
    tick(1);
    rd("glitch_sw_3", A_SW, 16'h0000);
    rd("glitch_stat", A_STAT, 16'h0001);
    io_sw1 = 1'b1;
    tick(2);
    rd("sw1_follow", A_SW, 16'h0002);
    rd("sw1_stat", A_STAT, 16'h0003);
    // reset clears everything
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    rd("post_reset_sw", A_SW, 16'h0000);
    tick(2);
    rd("post_reset_sw_lat", A_SW, 16'h0002);
`endif
    check("final_disp_reset", {9'b0, io_display}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
